noc_traffic_node: RTL
=====================

NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

Interface
REQ-001 Parameters SHALL be:
- X_ID, default 0: own mesh column, 4 bits used.
- Y_ID, default 0: own mesh row, 4 bits used.
- DEST_X_ID, default 1: destination column.
- DEST_Y_ID, default 1: destination row.
- DATA_W, default 32: flit width, legal range >= 24.
- PKT_LEN, default 4: flits per packet including header and tail, legal range 2..16.
- NUM_PKTS, default 8: packets to inject; 0 means unlimited.
- GAP, default 2: idle cycles between packets, legal range 0..255.
REQ-002 Ports SHALL be:
- noc_clk, in, 1: sole clock, all logic rising-edge.
- noc_rst_n, in, 1: asynchronous active-low reset.
- inject_en, in, 1: allows injection when high.
- receive_valid, in, 1: inbound flit valid.
- receive_ready, out, 1: inbound flit accepted.
- receive_flit, in, DATA_W: inbound flit.
- receive_is_header, in, 1: inbound header marker.
- receive_is_tail, in, 1: inbound tail marker.
- sender_valid, out, 1: outbound flit valid.
- sender_ready, in, 1: router accepts outbound flit.
- sender_flit, out, DATA_W: outbound flit.
- sender_is_header, out, 1: outbound header marker.
- sender_is_tail, out, 1: outbound tail marker.
- receive_num, out, 8: good packets received, wraps at 256.
- error_num, out, 8: bad packets received, wraps at 256.
- tx_done, out, 1: high once NUM_PKTS packets have been sent.

Function
REQ-003 A handshake SHALL occur on a cycle where valid and ready are both high.
REQ-004 While sender_valid=1 and sender_ready=0, sender_flit, sender_is_header and sender_is_tail SHALL hold stable.
REQ-005 The TX FSM SHALL have states IDLE, HEAD, BODY, GAP and DONE.
- IDLE->HEAD when inject_en=1 and packets remain.
- HEAD->BODY on header handshake.
- BODY->GAP on tail handshake; GAP=0 skips GAP.
- GAP->IDLE after GAP cycles.
- IDLE->DONE when the sent count reaches NUM_PKTS (NUM_PKTS!=0).
REQ-006 The header flit SHALL have sender_is_header=1 and the following fields, with all other bits 0:
- [3:0] DEST_X_ID
- [7:4] DEST_Y_ID
- [11:8] X_ID
- [15:12] Y_ID
- [23:16] 8-bit tx sequence number, 0 after reset, wrapping, incremented per packet sent.
REQ-007 Body flit k (1..PKT_LEN-1) SHALL be {seq[7:0], k[7:0]} zero-extended to DATA_W; flit PKT_LEN-1 SHALL carry sender_is_tail=1; no flit SHALL carry both markers.
REQ-008 Deasserting inject_en SHALL only block IDLE->HEAD; a packet in flight SHALL complete.
REQ-009 DONE SHALL be absorbing until reset; tx_done=1 in DONE; with NUM_PKTS=0, DONE SHALL be unreachable.
REQ-010 The RX checker SHALL track the states EXPECT_HEAD and IN_PKT, and on a header handshake SHALL latch seq, set flit index 1, and flag an error if [7:0] != {Y_ID, X_ID}.
REQ-011 On a body handshake the checker SHALL compare the flit against {seq, index} and flag an error on mismatch.
REQ-012 The per-packet error flag SHALL also be set by any of:
- tail with index != PKT_LEN-1;
- header while IN_PKT, which closes the old packet as an error and starts a new one;
- a non-header flit while in EXPECT_HEAD, which counts as one error packet immediately.
REQ-013 On the tail handshake, receive_num SHALL increment (flag clear) or error_num SHALL increment (flag set), visible the next cycle; at most one counter SHALL increment per packet.
REQ-014 A single-cycle flit with both header and tail set SHALL count as one error packet.

Reset
REQ-015 Assertion of noc_rst_n low SHALL asynchronously set the following, even mid-packet, after which the TX FSM SHALL restart in IDLE:
- sender_valid, sender_flit, sender_is_header, sender_is_tail, tx_done = 0;
- receive_num, error_num = 0;
- seq = 0;
- TX FSM = IDLE, RX = EXPECT_HEAD.
REQ-016 receive_ready SHALL be 0 during reset.

Configuration
REQ-017 With NOC_TRAFFIC_BACKPRESSURE_EN defined, receive_ready SHALL be bit 0 of a 16-bit Fibonacci LFSR.
- Taps 16,14,13,11; seed 16'hACE1 at reset; advances every cycle.
REQ-018 Without NOC_TRAFFIC_BACKPRESSURE_EN, receive_ready SHALL be 1 on every cycle after reset release.

Verification
REQ-019 TX wired to RX of a second node (IDs 1,1), PKT_LEN=4, NUM_PKTS=3, inject_en=1, sender_ready=1 -> receiver receive_num=3, error_num=0; sender tx_done=1.
REQ-020 sender_ready=0 for 5 cycles mid-body -> sender_flit held constant; packet still good, receive_num +1.
REQ-021 Inject body flit 1 as 32'h0000_0002 instead of 32'h0000_0001 for seq 0 -> error_num=1, receive_num unchanged.
REQ-022 Header with [7:0]=8'h22 into node (0,0) -> error_num=1 at tail.
REQ-023 noc_rst_n low during body flit 2 -> all outputs 0 asynchronously; after release, first header carries seq 0.
REQ-024 Backpressure macro defined, 20 packets looped back -> receive_num=20, error_num=0.

Source files
------------

// File: rtl/noc_traffic_node.sv
// noc_traffic_node: mesh traffic generator (TX) plus in-order packet checker (RX).
// Optional NOC_TRAFFIC_BACKPRESSURE_EN: receive_ready driven by a 16-bit Fibonacci LFSR.
module noc_traffic_node #(
  parameter int unsigned X_ID      = 0,
  parameter int unsigned Y_ID      = 0,
  parameter int unsigned DEST_X_ID = 1,
  parameter int unsigned DEST_Y_ID = 1,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PKT_LEN   = 4,
  parameter int unsigned NUM_PKTS  = 8,
  parameter int unsigned GAP       = 2
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              inject_en,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  output logic              sender_valid,
  input  logic              sender_ready,
  output logic [DATA_W-1:0] sender_flit,
  output logic              sender_is_header,
  output logic              sender_is_tail,
  output logic [7:0]        receive_num,
  output logic [7:0]        error_num,
  output logic              tx_done
);

  localparam logic [3:0] X4       = 4'(X_ID);
  localparam logic [3:0] Y4       = 4'(Y_ID);
  localparam logic [3:0] DEST_X4  = 4'(DEST_X_ID);
  localparam logic [3:0] DEST_Y4  = 4'(DEST_Y_ID);
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_GAP, TX_DONE} tx_state_t;
  typedef enum logic {RX_EXPECT_HEAD, RX_IN_PKT} rx_state_t;

  function automatic logic [DATA_W-1:0] body_flit(input logic [7:0] seq, input logic [7:0] idx);
    return DATA_W'({seq, idx});
  endfunction

  // ---------------- TX generator ----------------
  tx_state_t   tx_state;
  logic [7:0]  tx_seq;
  logic [7:0]  tx_idx;
  logic [7:0]  gap_cnt;
  logic [31:0] sent_cnt;
  logic        pkts_remain;

  assign pkts_remain = (NUM_PKTS == 0) || (sent_cnt != NUM_PKTS);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      tx_state         <= TX_IDLE;
      sender_valid     <= 1'b0;
      sender_flit      <= '0;
      sender_is_header <= 1'b0;
      sender_is_tail   <= 1'b0;
      tx_done          <= 1'b0;
      tx_seq           <= '0;
      tx_idx           <= '0;
      gap_cnt          <= '0;
      sent_cnt         <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!pkts_remain) begin
            tx_state <= TX_DONE;
            tx_done  <= 1'b1;
          end else if (inject_en) begin
            tx_state         <= TX_HEAD;
            sender_valid     <= 1'b1;
            sender_flit      <= DATA_W'({tx_seq, Y4, X4, DEST_Y4, DEST_X4});
            sender_is_header <= 1'b1;
            sender_is_tail   <= 1'b0;
          end
        end
        TX_HEAD: begin
          if (sender_ready) begin
            tx_state         <= TX_BODY;
            tx_idx           <= 8'd1;
            sender_flit      <= body_flit(tx_seq, 8'd1);
            sender_is_header <= 1'b0;
            sender_is_tail   <= (LAST_IDX == 8'd1);
          end
        end
        TX_BODY: begin
          if (sender_ready) begin
            if (sender_is_tail) begin
              sender_valid   <= 1'b0;
              sender_is_tail <= 1'b0;
              sender_flit    <= '0;
              tx_seq         <= tx_seq + 8'd1;
              sent_cnt       <= sent_cnt + 32'd1;
              gap_cnt        <= '0;
              tx_state       <= (GAP == 0) ? TX_IDLE : TX_GAP;
            end else begin
              tx_idx         <= tx_idx + 8'd1;
              sender_flit    <= body_flit(tx_seq, tx_idx + 8'd1);
              sender_is_tail <= ((tx_idx + 8'd1) == LAST_IDX);
            end
          end
        end
        TX_GAP: begin
          if (gap_cnt == GAP_LAST) tx_state <= TX_IDLE;
          else                     gap_cnt  <= gap_cnt + 8'd1;
        end
        TX_DONE: tx_done <= 1'b1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX checker ----------------
  rx_state_t  rx_state;
  logic [7:0] rx_seq;
  logic [7:0] rx_idx;
  logic       rx_err;
  logic       rx_hs;
  logic       in_pkt;
  logic       body_bad;

  assign rx_hs    = receive_valid & receive_ready;
  assign in_pkt   = (rx_state == RX_IN_PKT);
  assign body_bad = (receive_flit != body_flit(rx_seq, rx_idx));

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      rx_state    <= RX_EXPECT_HEAD;
      rx_seq      <= '0;
      rx_idx      <= '0;
      rx_err      <= 1'b0;
      receive_num <= '0;
      error_num   <= '0;
    end else if (rx_hs) begin
      if (receive_is_header) begin
        // An interrupted packet is an error in addition to whatever the new flit starts.
        if (receive_is_tail) begin
          error_num <= error_num + (in_pkt ? 8'd2 : 8'd1);
          rx_state  <= RX_EXPECT_HEAD;
        end else begin
          if (in_pkt) error_num <= error_num + 8'd1;
          rx_state <= RX_IN_PKT;
          rx_seq   <= receive_flit[23:16];
          rx_idx   <= 8'd1;
          rx_err   <= (receive_flit[7:0] != {Y4, X4});
        end
      end else if (!in_pkt) begin
        error_num <= error_num + 8'd1;
      end else if (receive_is_tail) begin
        if (rx_err || body_bad || (rx_idx != LAST_IDX)) error_num   <= error_num + 8'd1;
        else                                            receive_num <= receive_num + 8'd1;
        rx_state <= RX_EXPECT_HEAD;
      end else begin
        rx_idx <= rx_idx + 8'd1;
        rx_err <= rx_err | body_bad;
      end
    end
  end

`ifdef NOC_TRAFFIC_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        ready_en;

  // x^16+x^14+x^13+x^11+1, right-shifting form; ready_en keeps ready low until after reset.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      lfsr     <= 16'hACE1;
      ready_en <= 1'b0;
    end else begin
      lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      ready_en <= 1'b1;
    end
  end

  assign receive_ready = ready_en & lfsr[0];
`else
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) receive_ready <= 1'b0;
    else            receive_ready <= 1'b1;
  end
`endif

endmodule
